// File: rtl/ex_fw_unit_pkg.sv
// Shared types and helpers for the EX-stage forwarding / hazard unit.
// Holds the in-flight tag entry layout and the stage-readiness rule.
package ex_fw_unit_pkg;

  localparam int DEF_XLEN   = 32;
  localparam int DEF_REG_AW = 5;
  // Tag rd field is sized for the widest register file we expect; narrower
  // register addresses are zero-extended into it.
  localparam int FW_RD_W    = 8;

  typedef struct packed {
    logic               valid;
    logic               we;
    logic [FW_RD_W-1:0] rd;
    logic               is_load;
  } fw_entry_t;

  // A tagged result can be forwarded once it is not a load, or once the load
  // has reached the stage where its data exists.
  function automatic logic tag_ready(input fw_entry_t e, input int unsigned stage,
                                     input int unsigned load_lat);
    return !e.is_load || (stage >= load_lat);
  endfunction

endpackage

// File: rtl/ex_fw_unit_tag_pipe.sv
// Shadow pipeline of destination tags, one entry per bypassable stage.
// Stage 0 takes the issuing instruction, or a bubble on stall/flush/no-issue.
module fw_tag_pipe
  import ex_fw_unit_pkg::*;
#(
  parameter int REG_AW  = DEF_REG_AW,
  parameter int NUM_STG = 3
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      issue_valid_i,
  input  logic [REG_AW-1:0]         issue_rd_i,
  input  logic                      issue_we_i,
  input  logic                      issue_load_i,
  input  logic                      flush_i,
  input  logic                      stall_i,
  output fw_entry_t [NUM_STG-1:0]   tags_o
);

  fw_entry_t [NUM_STG-1:0] r_tags;
  fw_entry_t               w_new;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through it can leave a value held and infer a latch.
    w_new = '0;
    if (issue_valid_i && !stall_i && !flush_i) begin
      w_new.valid   = 1'b1;
      w_new.we      = issue_we_i;
      w_new.rd      = FW_RD_W'(issue_rd_i);
      w_new.is_load = issue_load_i;
    end
  end

  // NOTE: state is updated only with non-blocking assignments so every stage
  // samples its neighbour's pre-edge value and the shift order does not matter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: the whole tag array is small flops, not a RAM, so clearing it in
      // reset is cheap; only the valid bits strictly need it.
      r_tags <= '0;
    end else begin
      r_tags[0] <= w_new;
      for (int k = 1; k < NUM_STG; k++) begin
        r_tags[k] <= r_tags[k-1];
      end
    end
  end

  assign tags_o = r_tags;

endmodule

// File: rtl/ex_fw_unit.sv
// EX-stage operand forwarding and hazard detection: per-source youngest-match
// selection over the tag pipe, stall generation and a saturating stall counter.
module ex_fw_unit
  import ex_fw_unit_pkg::*;
#(
  parameter int XLEN     = DEF_XLEN,
  parameter int REG_AW   = DEF_REG_AW,
  parameter int NUM_SRC  = 2,
  parameter int NUM_STG  = 3,
  parameter int LOAD_LAT = 1
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                issue_valid_i,
  input  logic [REG_AW-1:0]                   issue_rd_i,
  input  logic                                issue_we_i,
  input  logic                                issue_load_i,
  input  logic                                flush_i,
  input  logic [NUM_SRC-1:0][REG_AW-1:0]      rs_addr_i,
  input  logic [NUM_SRC-1:0]                  rs_used_i,
  input  logic [NUM_SRC-1:0][XLEN-1:0]        rf_data_i,
  input  logic [NUM_STG-1:0][XLEN-1:0]        fw_data_i,
  output logic [NUM_SRC-1:0][XLEN-1:0]        operand_o,
  output logic [NUM_SRC-1:0][NUM_STG-1:0]     fw_hit_o,
  output logic                                stall_o,
  output logic [31:0]                         stall_cnt_o
);

  fw_entry_t [NUM_STG-1:0] w_tags;
  logic [NUM_SRC-1:0]      w_hazard;
  logic [NUM_STG-1:0]      w_ready;
  logic [31:0]             r_stall_cnt;

  fw_tag_pipe #(
    .REG_AW  (REG_AW),
    .NUM_STG (NUM_STG)
  ) u_tag_pipe (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .issue_valid_i (issue_valid_i),
    .issue_rd_i    (issue_rd_i),
    .issue_we_i    (issue_we_i),
    .issue_load_i  (issue_load_i),
    .flush_i       (flush_i),
    .stall_i       (stall_o),
    .tags_o        (w_tags)
  );

  // Readiness depends only on tags, keeping fw_data_i off the stall path.
  for (genvar k = 0; k < NUM_STG; k++) begin : g_ready
    assign w_ready[k] = tag_ready(w_tags[k], k, LOAD_LAT);
  end

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    logic               w_active;
    logic [NUM_STG-1:0] w_match;
    logic [NUM_STG-1:0] w_first;
    logic [NUM_STG-1:0] w_hit;

    assign w_active = rs_used_i[s] && (rs_addr_i[s] != '0);

    for (genvar k = 0; k < NUM_STG; k++) begin : g_stg
      assign w_match[k] = w_active && w_tags[k].valid && w_tags[k].we &&
                          (w_tags[k].rd != '0) &&
                          (w_tags[k].rd == FW_RD_W'(rs_addr_i[s]));
    end

    // Isolate the lowest set bit: the youngest producer shadows older ones.
    assign w_first     = w_match & (~w_match + NUM_STG'(1));
    assign w_hit       = w_first & w_ready;
    assign w_hazard[s] = |(w_first & ~w_ready);
    assign fw_hit_o[s] = w_hit;

    always_comb begin
      operand_o[s] = rf_data_i[s];
      for (int k = 0; k < NUM_STG; k++) begin
        if (w_hit[k]) operand_o[s] = fw_data_i[k];
      end
    end
  end

  assign stall_o = issue_valid_i && (|w_hazard);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
    end else if (stall_o && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;

endmodule

// File: tb/tb_ex_fw_unit.sv
// Self-checking bench for ex_fw_unit: directed scenarios with literal
// expectations plus a per-cycle comparison against an in-flight history model.
module tb_ex_fw_unit;

  localparam int XLEN     = 32;
  localparam int REG_AW   = 5;
  localparam int NUM_SRC  = 2;
  localparam int NUM_STG  = 3;
  localparam int LOAD_LAT = 1;

  logic                               clk_i = 1'b0;
  logic                               rst_i;
  logic                               issue_valid_i;
  logic [REG_AW-1:0]                  issue_rd_i;
  logic                               issue_we_i;
  logic                               issue_load_i;
  logic                               flush_i;
  logic [NUM_SRC-1:0][REG_AW-1:0]     rs_addr_i;
  logic [NUM_SRC-1:0]                 rs_used_i;
  logic [NUM_SRC-1:0][XLEN-1:0]       rf_data_i;
  logic [NUM_STG-1:0][XLEN-1:0]       fw_data_i;
  logic [NUM_SRC-1:0][XLEN-1:0]       operand_o;
  logic [NUM_SRC-1:0][NUM_STG-1:0]    fw_hit_o;
  logic                               stall_o;
  logic [31:0]                        stall_cnt_o;

  int n_tests = 0;
  int n_fail  = 0;
  logic cmp_en = 1'b0;

  always #5 clk_i = ~clk_i;

  ex_fw_unit #(
    .XLEN(XLEN), .REG_AW(REG_AW), .NUM_SRC(NUM_SRC),
    .NUM_STG(NUM_STG), .LOAD_LAT(LOAD_LAT)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .issue_valid_i (issue_valid_i),
    .issue_rd_i    (issue_rd_i),
    .issue_we_i    (issue_we_i),
    .issue_load_i  (issue_load_i),
    .flush_i       (flush_i),
    .rs_addr_i     (rs_addr_i),
    .rs_used_i     (rs_used_i),
    .rf_data_i     (rf_data_i),
    .fw_data_i     (fw_data_i),
    .operand_o     (operand_o),
    .fw_hit_o      (fw_hit_o),
    .stall_o       (stall_o),
    .stall_cnt_o   (stall_cnt_o)
  );

  // Model: hist[a] is the instruction that entered EX a+1 cycles ago.
  typedef struct packed {
    logic              valid;
    logic              we;
    logic              load;
    logic [REG_AW-1:0] rd;
  } m_ent_t;

  m_ent_t      hist [NUM_STG];
  logic [31:0] m_cnt;
  logic [NUM_SRC-1:0][XLEN-1:0]    exp_op;
  logic [NUM_SRC-1:0][NUM_STG-1:0] exp_hit;
  logic                            exp_stall;

  always_comb begin
    logic any_haz;
    logic found;
    any_haz = 1'b0;
    found   = 1'b0;
    for (int s = 0; s < NUM_SRC; s++) begin
      exp_op[s]  = rf_data_i[s];
      exp_hit[s] = '0;
      found      = 1'b0;
      if (rs_used_i[s] && rs_addr_i[s] != 0) begin
        for (int a = 0; a < NUM_STG; a++) begin
          if (!found && hist[a].valid && hist[a].we && hist[a].rd != 0 &&
              hist[a].rd == rs_addr_i[s]) begin
            found = 1'b1;
            if (hist[a].load && a < LOAD_LAT) any_haz = 1'b1;
            else begin
              exp_op[s]     = fw_data_i[a];
              exp_hit[s][a] = 1'b1;
            end
          end
        end
      end
    end
    exp_stall = issue_valid_i && any_haz;
  end

  always @(posedge clk_i) begin
    if (rst_i) begin
      for (int a = 0; a < NUM_STG; a++) hist[a] <= '0;
      m_cnt <= 32'd0;
    end else begin
      for (int a = 1; a < NUM_STG; a++) hist[a] <= hist[a-1];
      if (issue_valid_i && !exp_stall && !flush_i)
        hist[0] <= '{valid: 1'b1, we: issue_we_i, load: issue_load_i, rd: issue_rd_i};
      else
        hist[0] <= '0;
      if (exp_stall && m_cnt != 32'hFFFF_FFFF) m_cnt <= m_cnt + 32'd1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk_i) begin
    if (cmp_en) begin
      for (int s = 0; s < NUM_SRC; s++) begin
        check($sformatf("model op[%0d]", s), 64'(operand_o[s]), 64'(exp_op[s]));
        check($sformatf("model hit[%0d]", s), 64'(fw_hit_o[s]), 64'(exp_hit[s]));
      end
      check("model stall", 64'(stall_o), 64'(exp_stall));
      check("model stall_cnt", 64'(stall_cnt_o), 64'(m_cnt));
    end
  end

  task automatic idle();
    issue_valid_i = 1'b0; issue_rd_i = '0; issue_we_i = 1'b0;
    issue_load_i  = 1'b0; flush_i    = 1'b0;
    rs_used_i     = '0;
    for (int k = 0; k < NUM_STG; k++) fw_data_i[k] = 32'hC0DE_0000 + 32'(k);
    for (int s = 0; s < NUM_SRC; s++) set_src(s, '0, 1'b0);
  endtask

  task automatic set_src(input int s, input logic [REG_AW-1:0] addr, input logic used);
    rs_addr_i[s] = addr;
    rs_used_i[s] = used;
    rf_data_i[s] = 32'hF0F0_0000 + 32'(addr) + 32'(s << 8);
  endtask

  task automatic issue(input logic [REG_AW-1:0] rd, input logic we, input logic ld);
    issue_valid_i = 1'b1; issue_rd_i = rd; issue_we_i = we; issue_load_i = ld;
  endtask

  task automatic next_cycle();
    @(posedge clk_i); #1;
    idle();
  endtask

  initial begin
    rst_i = 1'b1;
    idle();
    repeat (2) @(posedge clk_i);
    #1;
    rst_i  = 1'b0;
    cmp_en = 1'b1;

    // No producers in flight: register file passes through.
    set_src(0, 5'd3, 1'b1); set_src(1, 5'd4, 1'b1);
    @(negedge clk_i);
    check("reset op0", 64'(operand_o[0]), 64'h0000_0000_F0F0_0003);
    check("reset op1", 64'(operand_o[1]), 64'h0000_0000_F0F0_0104);
    check("reset hit", 64'(fw_hit_o), 64'h0);
    check("reset stall", 64'(stall_o), 64'h0);
    check("reset cnt", 64'(stall_cnt_o), 64'h0);

    // ALU x5 then consumer: forward from stage 0.
    next_cycle(); issue(5'd5, 1'b1, 1'b0);
    next_cycle(); set_src(0, 5'd5, 1'b1); fw_data_i[0] = 32'hDEAD_BEEF;
    @(negedge clk_i);
    check("alu fwd op0", 64'(operand_o[0]), 64'h0000_0000_DEAD_BEEF);
    check("alu fwd hit0", 64'(fw_hit_o[0]), 64'b001);
    check("alu fwd stall", 64'(stall_o), 64'h0);

    // Load x7 then immediately dependent consumer on rs2: one stall cycle.
    next_cycle(); issue(5'd7, 1'b1, 1'b1);
    next_cycle(); issue(5'd0, 1'b0, 1'b0); set_src(1, 5'd7, 1'b1);
    @(negedge clk_i);
    check("load-use stall", 64'(stall_o), 64'h1);
    check("load-use hit1 during stall", 64'(fw_hit_o[1]), 64'h0);
    next_cycle(); issue(5'd0, 1'b0, 1'b0); set_src(1, 5'd7, 1'b1);
    @(negedge clk_i);
    check("load-use release stall", 64'(stall_o), 64'h0);
    check("load-use hit1", 64'(fw_hit_o[1]), 64'b010);
    check("load-use op1", 64'(operand_o[1]), 64'h0000_0000_C0DE_0001);
    check("load-use cnt", 64'(stall_cnt_o), 64'h1);

    // Two writes to x9 back to back: younger stage wins.
    next_cycle(); issue(5'd9, 1'b1, 1'b0);
    next_cycle(); issue(5'd9, 1'b1, 1'b0);
    next_cycle(); set_src(0, 5'd9, 1'b1);
    fw_data_i[0] = 32'h9999_0000; fw_data_i[1] = 32'h9999_0001;
    @(negedge clk_i);
    check("shadow hit0", 64'(fw_hit_o[0]), 64'b001);
    check("shadow op0", 64'(operand_o[0]), 64'h0000_0000_9999_0000);

    // x0 producer is ignored; unused source never hits.
    next_cycle(); issue(5'd0, 1'b1, 1'b0);
    next_cycle(); issue(5'd11, 1'b1, 1'b0); set_src(0, 5'd0, 1'b1);
    @(negedge clk_i);
    check("x0 hit0", 64'(fw_hit_o[0]), 64'h0);
    check("x0 op0", 64'(operand_o[0]), 64'h0000_0000_F0F0_0000);
    next_cycle(); issue(5'd0, 1'b0, 1'b0); set_src(0, 5'd11, 1'b0); set_src(1, 5'd0, 1'b1);
    @(negedge clk_i);
    check("unused hit", 64'(fw_hit_o), 64'h0);
    check("unused op0", 64'(operand_o[0]), 64'h0000_0000_F0F0_000B);
    check("unused stall", 64'(stall_o), 64'h0);

    // Flushed load leaves no trace.
    next_cycle(); issue(5'd8, 1'b1, 1'b1); flush_i = 1'b1;
    next_cycle(); issue(5'd0, 1'b0, 1'b0); set_src(0, 5'd8, 1'b1);
    @(negedge clk_i);
    check("flush stall", 64'(stall_o), 64'h0);
    check("flush op0", 64'(operand_o[0]), 64'h0000_0000_F0F0_0008);

    // Reset arriving during a load-use stall.
    next_cycle(); issue(5'd12, 1'b1, 1'b1);
    next_cycle(); issue(5'd0, 1'b0, 1'b0); set_src(1, 5'd12, 1'b1); rst_i = 1'b1;
    @(negedge clk_i);
    check("pre-reset stall", 64'(stall_o), 64'h1);
    next_cycle(); rst_i = 1'b0; issue(5'd0, 1'b0, 1'b0); set_src(1, 5'd12, 1'b1);
    @(negedge clk_i);
    check("post-reset stall", 64'(stall_o), 64'h0);
    check("post-reset cnt", 64'(stall_cnt_o), 64'h0);

    // Mixed traffic on a small register window, checked by the model each cycle.
    for (int i = 0; i < 400; i++) begin
      next_cycle();
      if ($urandom_range(0, 3) != 0)
        issue(REG_AW'($urandom_range(0, 5)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      flush_i = ($urandom_range(0, 7) == 0);
      for (int s = 0; s < NUM_SRC; s++)
        set_src(s, REG_AW'($urandom_range(0, 5)), ($urandom_range(0, 4) != 0));
      for (int k = 0; k < NUM_STG; k++) fw_data_i[k] = $urandom;
    end

    next_cycle();
    @(negedge clk_i);
    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
